// File: rtl/hybrid_noc_router_output_arbiter.sv
// Per-output-port arbiter and flit mux. It grants the port to one input for a whole
// packet, uses round-robin order between packets, and drives one registered output stage.
module hybrid_noc_router_output_arbiter #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned PORTS      = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORTS*FLIT_WIDTH-1:0]   i_in_flit,
  input  logic [PORTS-1:0]              i_in_valid,
  input  logic [PORTS-1:0]              i_in_last,
  output logic [PORTS-1:0]              o_in_ready,
  output logic [FLIT_WIDTH-1:0]         o_out_flit,
  output logic                          o_out_valid,
  output logic                          o_out_last,
  input  logic                          i_out_ready,
  output logic [PORTS-1:0]              o_out_grant
);

  localparam int unsigned PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                r_state;
  logic [PTR_W-1:0]      r_ptr;
  logic [PTR_W-1:0]      r_owner;
  logic [PORTS-1:0]      r_grant;
  logic [FLIT_WIDTH-1:0] r_out_flit;
  logic                  r_out_valid;
  logic                  r_out_last;

  logic                  w_found;
  logic [PTR_W-1:0]      w_win;
  logic [PTR_W-1:0]      w_sel;
  logic [PTR_W-1:0]      w_next_ptr;
  logic [PORTS-1:0]      w_sel_onehot;
  logic [FLIT_WIDTH-1:0] w_sel_flit;
  logic                  w_sel_last;
  logic                  w_req;
  logic                  w_can_update;
  logic                  w_xfer;

  // Round-robin winner: first valid input at or after r_ptr, wrapping modulo PORTS.
  always_comb begin
    int unsigned      idx;
    logic [PTR_W-1:0] idx_p;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    idx_p   = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      idx = 32'(r_ptr) + i;
      if (idx >= PORTS) begin
        idx = idx - PORTS;
      end
      idx_p = PTR_W'(idx);
      if (!w_found && i_in_valid[idx_p]) begin
        w_found = 1'b1;
        w_win   = idx_p;
      end
    end
  end

  // The locked owner keeps the port; in idle the same-cycle winner takes it.
  always_comb begin
    w_sel        = (r_state == ST_LOCKED) ? r_owner : w_win;
    w_req        = (r_state == ST_LOCKED) | w_found;
    w_can_update = ~r_out_valid | i_out_ready;
    w_sel_onehot = PORTS'(1) << w_sel;
    w_sel_flit   = i_in_flit[32'(w_sel)*FLIT_WIDTH +: FLIT_WIDTH];
    w_sel_last   = i_in_last[w_sel];
    w_next_ptr   = (w_sel == PTR_W'(PORTS - 1)) ? '0 : w_sel + PTR_W'(1);
    o_in_ready   = (rst_n && w_req && w_can_update) ? w_sel_onehot : '0;
    w_xfer       = rst_n & w_req & w_can_update & i_in_valid[w_sel];
  end

  // Packet lock state, priority pointer and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_grant     <= '0;
      r_out_flit  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_xfer) begin
      r_out_flit  <= w_sel_flit;
      r_out_last  <= w_sel_last;
      r_out_valid <= 1'b1;
      if (w_sel_last) begin
        r_state <= ST_IDLE;
        r_grant <= '0;
        r_ptr   <= w_next_ptr;
      end else begin
        r_state <= ST_LOCKED;
        r_grant <= w_sel_onehot;
        r_owner <= w_sel;
      end
    end else begin
      r_out_valid <= r_out_valid & ~i_out_ready;
    end
  end

  assign o_out_flit  = r_out_flit;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_out_grant = r_grant;

endmodule

// File: doc/hybrid_noc_router_output_arbiter.md
# hybrid_noc_router_output_arbiter

Per-output-port arbiter and flit multiplexer for the hybrid NoC router with source routing. It collects the one-hot output requests from all input-port lookup stages and grants the output port to one input for a whole packet, using round-robin order between packets. It drives one registered output stage toward the link or output buffer. One instance sits behind each router output port.

## Interface
- FLIT_WIDTH, 32, flit width in bits; must match the lookup stages.
- PORTS, 5, number of requesting input ports; valid range 2..16.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low; clears all state immediately.
- in_flit  in  PORTS*FLIT_WIDTH  flit from input p at bits [p*FLIT_WIDTH +: FLIT_WIDTH].
- in_valid  in  PORTS  bit p: input p requests this output. This is the lookup stage's out_valid bit for this port.
- in_last  in  PORTS  bit p: the flit on input p is the last flit of its packet.
- in_ready  out  PORTS  bit p: this arbiter accepts input p's flit in this cycle.
- out_flit  out  FLIT_WIDTH  registered flit.
- out_valid  out  1  registered valid.
- out_last  out  1  registered last flag.
- out_ready  in  1  downstream accepts out_flit.
- out_grant  out  PORTS  registered one-hot owner of the port; 0 when idle.

## Operation
- Output stage:
  - can_update = ~out_valid | out_ready.
  - A flit transfer from input p happens when in_valid[p] & in_ready[p].
- State IDLE (out_grant == 0):
  - Winner w is the first p with in_valid[p] set, scanning from prio_ptr upward with wrap-around modulo PORTS.
  - in_ready[w] = can_update; all other in_ready bits are 0.
  - If no input is valid, all in_ready bits are 0.
  - On transfer with in_last[w]=0: go to LOCKED and set out_grant = 1<<w.
  - On transfer with in_last[w]=1 (single-flit packet): stay IDLE and set prio_ptr = (w+1) mod PORTS.
- State LOCKED (owner g):
  - in_ready[g] = can_update; all other in_ready bits are 0, whatever their in_valid.
  - On transfer with in_last[g]=1: go to IDLE, clear out_grant, set prio_ptr = (g+1) mod PORTS.
  - A deasserted in_valid[g] mid-packet inserts bubbles and the lock is held. No timeout.
- Output register update:
  - On any transfer: out_flit <= in_flit of the accepted input, out_last <= its in_last, out_valid <= 1.
  - Otherwise out_valid <= out_valid & ~out_ready. out_flit and out_last are held.
- The flit is passed unmodified; header rewriting stays in the lookup stage.
- prio_ptr width is $clog2(PORTS) bits and never holds a value >= PORTS.

## Timing
- Reset values:
  - out_valid=0, out_last=0, out_flit=0, out_grant=0.
  - State IDLE, prio_ptr=0.
  - in_ready=0 while rst_n is low.
- Latency: a flit accepted in cycle n appears on out_flit with out_valid=1 in cycle n+1.
- Throughput: 1 flit/cycle while out_ready=1.
- Back-to-back packets: no idle cycle between the last flit of one packet and the head of the next packet, from the same or a different input. The arbitration in IDLE is combinational in the same cycle.
- Backpressure:
  - out_valid=1 & out_ready=0 forces all in_ready to 0.
  - out_flit, out_last and out_valid hold stable until accepted.
- Simultaneous out_ready=1 and a new transfer in one cycle: the output register reloads without a bubble.
- in_ready depends combinationally on in_valid, out_ready and state. No path from in_ready back to in_valid is allowed.
- Reset asserted mid-packet: state is dropped immediately. The partial packet is lost and upstream must also be reset.

## Test plan
- Reset, then input 2 sends a 3-flit packet A0..A2 with out_ready=1:
  - out_flit = A0, A1, A2 in cycles 1..3 after acceptance; out_last only with A2.
  - out_grant = 0b00100 while locked, then 0.
  - prio_ptr = 3 afterwards.
- All 5 inputs valid with 2-flit packets, out_ready=1:
  - Grant order 0,1,2,3,4,0 with no idle cycle between packets.
  - No interleaving of flits from different packets.
- Input 1 locked mid-packet, input 3 valid, in_valid[1] low for 4 cycles:
  - in_ready[3] stays 0.
  - out_valid drops after draining, then input 1 resumes and its packet completes.
- out_ready=0 for 5 cycles with a flit in the output register:
  - out_flit is stable and all in_ready are 0.
  - On release, exactly one transfer occurs per cycle.
- Single-flit packets (in_last=1) alternating on inputs 0 and 4, both always valid:
  - Grants alternate 0,4,0,4; out_grant stays 0 throughout.
- rst_n pulsed low while LOCKED, asynchronous to clk:
  - out_valid, out_grant and in_ready go to 0 before the next edge.
  - After release, arbitration restarts at prio_ptr=0.
